// File: rtl/data_mem_responder_if.sv
// Processor data-memory bus between the CPU memory stage (master) and the
// wait-state data-memory responder (slave).
interface data_mem_responder_if;
    logic        iReq;
    logic        iWrite;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic [3:0]  iByteEn;
    logic        oReady;
    logic [31:0] oRData;
    logic        oErr;
    logic        oBusy;

    modport master (
        output iReq, iWrite, iAddr, iWData, iByteEn,
        input  oReady, oRData, oErr, oBusy
    );

    modport slave (
        input  iReq, iWrite, iAddr, iWData, iByteEn,
        output oReady, oRData, oErr, oBusy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM behind a base-address decode,
// answering load/store requests after a configurable number of wait states.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    data_mem_responder_if.slave   bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             enter_resp_s;
    logic             sel_write_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic [3:0]       sel_be_s;
    logic [31:0]      offset_s;
    logic             ok_s;
    logic [IDX_W-1:0] idx_s;
    logic             we_s;

    logic [31:0]      mem_q [DEPTH_WORDS];

    // Offsets are taken modulo 2^32, so addresses below the base wrap to huge values and fail the span test.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (off < SPAN) && (addr[1:0] == 2'b00);
    endfunction

    // Request sequencing; with zero wait states RESP is entered straight from IDLE, so live inputs are used.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        enter_resp_s = 1'b0;
        sel_write_s  = write_q;
        sel_addr_s   = addr_q;
        sel_wdata_s  = wdata_q;
        sel_be_s     = be_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iReq) begin
                    write_d     = bus.iWrite;
                    addr_d      = bus.iAddr;
                    wdata_d     = bus.iWData;
                    be_d        = bus.iByteEn;
                    sel_write_s = bus.iWrite;
                    sel_addr_s  = bus.iAddr;
                    sel_wdata_s = bus.iWData;
                    sel_be_s    = bus.iByteEn;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Address decode and registered response values computed for the edge entering RESP.
    always_comb begin
        offset_s = sel_addr_s - BASE_ADDR;
        ok_s     = addr_ok(sel_addr_s);
        idx_s    = offset_s[IDX_W+1:2];
        we_s     = enter_resp_s && sel_write_s && ok_s && iRST_n;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = 32'd0;
        if (enter_resp_s) begin
            ready_d = 1'b1;
            err_d   = !ok_s;
            if (ok_s && !sel_write_s) begin
                rdata_d = mem_q[idx_s];
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents survive reset; only enabled byte lanes are written.
    always_ff @(posedge iCLK) begin
        if (we_s) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_be_s[k]) begin
                    mem_q[idx_s][8*k +: 8] <= sel_wdata_s[8*k +: 8];
                end
            end
        end
    end

    assign bus.oReady = ready_q;
    assign bus.oErr   = err_q;
    assign bus.oRData = rdata_q;
    assign bus.oBusy  = (state_q != ST_IDLE);

endmodule
